// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, sub-tick landmarks,
// frame configuration and received-character payload.
package uart_pkg;

  localparam int unsigned MID_TICK      = 7;
  localparam int unsigned LAST_TICK     = 15;
  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned SUB_W         = 4;
  localparam int unsigned BIT_IDX_W     = 3;
  localparam int unsigned CHAR_W        = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_e;

  typedef struct packed {
    logic [1:0] data_bits;
    logic       stop2;
    logic       par_en;
    logic       even;
  } frame_cfg_t;

  typedef struct packed {
    logic [CHAR_W-1:0] data;
    logic              perr;
    logic              ferr;
  } rx_char_t;

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive holding-register handshake between the UART receiver (master)
// and the host-side register block (slave).
interface uart_rx_core_if;
  import uart_pkg::*;

  logic [CHAR_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversampling prescaler; tick every divisor+1 clocks.
// A new divisor is picked up only when the counter wraps.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_tick16_c
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             w_wrap;

  assign w_wrap     = (r_cnt == r_div);
  assign o_tick16_c = w_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_div <= i_divisor;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_div <= i_divisor;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampling UART receiver with single-entry valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 bit voting at sub-ticks 6/7/8.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       data_bits,
  input  logic             stop_bits,
  input  logic             parity_en,
  input  logic             even_parity,
  input  logic             sin,
  output logic             busy,
  uart_rx_core_if.master   rx_if
);

  logic                 r_sync1, r_sync2, r_sin_d;
  logic                 w_s_in, w_fall, w_tick16;
  state_e               r_state, w_state_nxt;
  logic [SUB_W-1:0]     r_sub;
  frame_cfg_t           r_cfg;
  logic [BIT_IDX_W-1:0] r_bit_idx, w_last_idx;
  logic [CHAR_W-1:0]    r_shift;
  logic                 r_par, r_perr, r_ferr;
  rx_char_t             r_hold;
  logic                 r_valid, r_ovr, r_busy;
  logic                 w_bit, w_samp, w_last, w_exp_par;
  logic                 w_start, w_shift, w_bit_adv, w_par_chk, w_stop_chk, w_done;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk        (clk),
    .rst        (rst),
    .i_divisor  (divisor),
    .o_tick16_c (w_tick16)
  );

  assign w_s_in = r_sync2;
  assign w_fall = r_sin_d & ~r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sin_d <= 1'b1;
    end else begin
      r_sync1 <= sin;
      r_sync2 <= r_sync1;
      r_sin_d <= r_sync2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned SAMPLE_TICK = MID_TICK + 1;
  logic r_v6, r_v7;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v6 <= 1'b1;
      r_v7 <= 1'b1;
    end else if (w_tick16) begin
      if (r_sub == SUB_W'(MID_TICK - 1)) r_v6 <= w_s_in;
      if (r_sub == SUB_W'(MID_TICK))     r_v7 <= w_s_in;
    end
  end

  assign w_bit = (r_v6 & r_v7) | (r_v6 & w_s_in) | (r_v7 & w_s_in);
`else
  localparam int unsigned SAMPLE_TICK = MID_TICK;
  assign w_bit = w_s_in;
`endif

  assign w_samp     = w_tick16 && (r_sub == SUB_W'(SAMPLE_TICK));
  assign w_last     = w_tick16 && (r_sub == SUB_W'(LAST_TICK));
  assign w_last_idx = BIT_IDX_W'(32'(r_cfg.data_bits) + DATA_BITS_MIN - 1);
  assign w_exp_par  = r_par ^ ~r_cfg.even;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_fall) w_state_nxt = START;
      START: begin
        if (w_samp && w_bit) w_state_nxt = IDLE;
        else if (w_last)     w_state_nxt = DATA;
      end
      DATA:   if (w_last && (r_bit_idx == w_last_idx))
                w_state_nxt = r_cfg.par_en ? PARITY : STOP1;
      PARITY: if (w_last) w_state_nxt = STOP1;
      STOP1: begin
        if (r_cfg.stop2) begin
          if (w_last) w_state_nxt = STOP2;
        end else if (w_samp) begin
          w_state_nxt = IDLE;
        end
      end
      STOP2:  if (w_samp) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-state datapath strobes; the final stop sample completes the frame.
  always_comb begin
    w_start    = 1'b0;
    w_shift    = 1'b0;
    w_bit_adv  = 1'b0;
    w_par_chk  = 1'b0;
    w_stop_chk = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE:   w_start = w_fall;
      DATA: begin
        w_shift   = w_samp;
        w_bit_adv = w_last;
      end
      PARITY: w_par_chk = w_samp;
      STOP1: begin
        w_stop_chk = w_samp;
        w_done     = w_samp && !r_cfg.stop2;
      end
      STOP2: begin
        w_stop_chk = w_samp;
        w_done     = w_samp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub     <= '0;
      r_busy    <= 1'b0;
      r_cfg     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sub  <= (w_state_nxt != r_state) ? '0 : (w_tick16 ? r_sub + SUB_W'(1) : r_sub);
      r_busy <= (w_state_nxt != IDLE);
      if (w_start) begin
        r_cfg     <= '{data_bits: data_bits, stop2: stop_bits,
                       par_en: parity_en, even: even_parity};
        r_bit_idx <= '0;
        r_shift   <= '0;
        r_par     <= 1'b0;
        r_perr    <= 1'b0;
        r_ferr    <= 1'b0;
      end
      if (w_shift) begin
        r_shift[r_bit_idx] <= w_bit;
        r_par              <= r_par ^ w_bit;
      end
      if (w_bit_adv)  r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
      if (w_par_chk)  r_perr    <= (w_bit != w_exp_par);
      if (w_stop_chk) r_ferr    <= r_ferr | ~w_bit;
    end
  end

  // Holding register: a load in the same cycle as an accept wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done) begin
        if (!r_valid || rx_if.rx_ready) begin
          r_hold  <= '{data: r_shift, perr: r_perr, ferr: r_ferr | ~w_bit};
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data     = r_hold.data;
  assign rx_if.parity_err  = r_hold.perr;
  assign rx_if.frame_err   = r_hold.ferr;
  assign rx_if.rx_valid    = r_valid;
  assign rx_if.overrun_err = r_ovr;
  assign busy              = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: a bit-level UART driver pushes expected
// characters, a negedge monitor pops and compares on every holding-register load.
module tb_uart_rx_core;

  localparam int unsigned DIV_W = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] divisor = '0;
  logic [1:0]       data_bits = 2'd3;
  logic             stop_bits = 1'b0;
  logic             parity_en = 1'b0;
  logic             even_parity = 1'b0;
  logic             sin = 1'b1;
  logic             busy;

  uart_rx_core_if u_if ();

  uart_rx_core #(.DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .divisor     (divisor),
    .data_bits   (data_bits),
    .stop_bits   (stop_bits),
    .parity_en   (parity_en),
    .even_parity (even_parity),
    .sin         (sin),
    .busy        (busy),
    .rx_if       (u_if)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_err = 0;
  int   n_push = 0, n_load = 0, n_ovr = 0, n_vcyc = 0;
  bit   busy_seen = 1'b0;
  logic prev_v = 1'b0, prev_r = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Load = valid rises, or valid stays high across a cycle in which it was accepted.
  always @(negedge clk) begin
    if (u_if.overrun_err === 1'b1) n_ovr++;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (u_if.rx_valid === 1'b1) n_vcyc++;
    if (u_if.rx_valid === 1'b1 && (prev_v !== 1'b1 || prev_r === 1'b1)) begin
      n_load++;
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("rx_data",    32'(u_if.rx_data),    32'(mon_e.data));
        chk("parity_err", 32'(u_if.parity_err), 32'(mon_e.perr));
        chk("frame_err",  32'(u_if.frame_err),  32'(mon_e.ferr));
      end
    end
    prev_v = u_if.rx_valid;
    prev_r = u_if.rx_ready;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bitclk();
    return 16 * (int'(divisor) + 1);
  endfunction

  task automatic drive_bit(input logic b);
    sin = b;
    tick(bitclk());
  endtask

  task automatic set_cfg(input int div, input int db, input bit st2, input bit pe, input bit ev);
    divisor     = DIV_W'(div);
    data_bits   = 2'(db);
    stop_bits   = st2;
    parity_en   = pe;
    even_parity = ev;
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic send(input logic [7:0] d, input bit flip_par, input bit stop_low);
    int   nb;
    logic p;
    nb = int'(data_bits) + 5;
    p  = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      drive_bit(d[i]);
      p = p ^ d[i];
    end
    if (parity_en) drive_bit((even_parity ? p : ~p) ^ flip_par);
    drive_bit(~stop_low);
    if (stop_bits) drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic send_exp(input logic [7:0] d, input bit flip_par, input bit stop_low);
    logic [7:0] m;
    exp_t       e;
    m = 8'hFF >> (3 - int'(data_bits));
    e.data = d & m;
    e.perr = flip_par & parity_en;
    e.ferr = stop_low;
    sb_q.push_back(e);
    n_push++;
    send(d, flip_par, stop_low);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         v0, o0, wait_n;
    logic [7:0] v5a;
    exp_t       brk;

    u_if.rx_ready = 1'b1;
    tick(4);
    chk("reset_rx_data",     32'(u_if.rx_data),     32'h0);
    chk("reset_rx_valid",    32'(u_if.rx_valid),    32'h0);
    chk("reset_parity_err",  32'(u_if.parity_err),  32'h0);
    chk("reset_frame_err",   32'(u_if.frame_err),   32'h0);
    chk("reset_overrun_err", 32'(u_if.overrun_err), 32'h0);
    chk("reset_busy",        32'(busy),             32'h0);
    rst = 1'b0;
    tick(2);

    // 8N1 at full rate
    set_cfg(0, 3, 0, 0, 0);
    v0 = n_vcyc;
    send_exp(8'hA5, 0, 0);
    chk("valid_one_cycle", 32'(n_vcyc - v0), 32'd1);
    chk("busy_after_8n1",  32'(busy),        32'd0);

    // 7E2: good parity, then inverted parity bit
    set_cfg(3, 2, 1, 1, 1);
    send_exp(8'h35, 0, 0);
    send_exp(8'h35, 1, 0);

    // 5O1: stop bit low, then a clean frame
    set_cfg(0, 0, 0, 1, 0);
    send_exp(8'h1F, 0, 1);
    send_exp(8'h0A, 0, 0);

    // Randomized formats and data
    for (int k = 0; k < 4; k++) begin
      set_cfg(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      send_exp(8'($urandom), 0, 0);
    end

    // Break: line held low long past a frame
    set_cfg(0, 3, 0, 0, 0);
    brk = '{data: 8'h00, perr: 1'b0, ferr: 1'b1};
    sb_q.push_back(brk);
    n_push++;
    sin = 1'b0;
    tick(12 * 16);
    chk("busy_idle_during_break", 32'(busy), 32'd0);
    sin = 1'b1;
    tick(3 * 16);

    // Overrun: consumer stalled across two frames
    u_if.rx_ready = 1'b0;
    o0 = n_ovr;
    send_exp(8'h11, 0, 0);
    send(8'h22, 0, 0);
    chk("overrun_hold_data",  32'(u_if.rx_data),  32'h11);
    chk("overrun_hold_valid", 32'(u_if.rx_valid), 32'd1);
    chk("overrun_pulses",     32'(n_ovr - o0),    32'd1);
    u_if.rx_ready = 1'b1;
    tick(2);
    chk("valid_after_accept", 32'(u_if.rx_valid), 32'd0);

    // Short low glitch is rejected as a false start
    set_cfg(1, 3, 0, 0, 0);
    busy_seen = 1'b0;
    sin = 1'b0;
    tick(4);
    sin = 1'b1;
    tick(60);
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_busy_idle", 32'(busy),      32'd0);

    // Reset in the middle of the data bits of 0x5A
    set_cfg(0, 3, 0, 0, 0);
    o0  = n_ovr;
    v5a = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(v5a[i]);
    rst = 1'b1;
    tick(2);
    chk("midframe_reset_busy",  32'(busy),          32'd0);
    chk("midframe_reset_valid", 32'(u_if.rx_valid), 32'd0);
    rst = 1'b0;
    sin = 1'b1;
    tick(48);
    chk("post_reset_busy", 32'(busy), 32'd0);
    send_exp(8'hC3, 0, 0);
    chk("no_overrun_around_reset", 32'(n_ovr - o0), 32'd0);

    wait_n = 0;
    while (sb_q.size() != 0 && wait_n < 2000) begin
      tick(1);
      wait_n++;
    end
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    chk("load_count",       32'(n_load),      32'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
